ikaopm_slotgen: RTL and testbench
=================================

# ikaopm_slotgen

Parametrised successor to the chip timing generator. Derives phi1 and its clock enables from the phiM enable with a configurable divide ratio. Runs a slot counter of configurable length and produces SH1/SH2 windows with configurable position, length and delay. Replaces the fixed cycle decoder with a runtime-programmable strobe table. It sits at the top of the core and feeds every operator/EG/PG/LFO pipeline stage.

## Interface
- SLOTS, 32: slots per frame, 2..64.
- SLOT_W, 5: slot counter width; 2^SLOT_W >= SLOTS.
- PHI_DIV, 2: phiM enables per phi1 period; even, >= 2.
- N_STROBE, 8: strobe table entries / strobe outputs, 1..16.
- SH1_START, 8 / SH2_START, 24: first slot of each SH window.
- SH_LEN, 8: window length in slots.
- SH_DELAY, 5: phi1 cycles of SH pipeline delay, >= 1.
- SYNC_STAGES, 2: IC_n synchroniser depth, >= 2.
- i_EMUCLK  in  1  emulator master clock; all logic on posedge.
- i_RST  in  1  asynchronous, active-high reset.
- i_phiM_PCEN_n  in  1  phiM enable, active low.
- i_IC_n  in  1  chip initial-clear, active low, asynchronous to phiM.
- i_STB_WE  in  1  strobe table write strobe, single EMUCLK cycle.
- i_STB_SEL  in  clog2(N_STROBE) (min 1)  entry index.
- i_STB_SLOT  in  SLOT_W  compare slot.
- i_STB_EN  in  1  entry enable.
- o_MRST_n  out  1  core internal reset, active low.
- o_phi1  out  1  phi1 level.
- o_phi1_PCEN_n / o_phi1_NCEN_n  out  1  phi1 rising/falling enable, active low, combinational.
- o_SLOT  out  SLOT_W  current slot.
- o_STROBE  out  N_STROBE  decoded slot strobes.
- o_SH1 / o_SH2  out  1  sample-hold windows.
- o_FRAME  out  1  end-of-frame pulse.
- o_STB_ERR  out  1  sticky illegal-write flag.

## Operation
- i_RST high: div_cnt=0, o_phi1=1, o_MRST_n=0, synchroniser=all 0, o_SLOT=0, o_STROBE=0, SH pipelines=0, o_SH1=o_SH2=0, o_FRAME=0, o_STB_ERR=0, table entry k: cmp=k mod SLOTS, en=0. Combinational enables follow div_cnt=0.
- Divider: div_cnt advances 0..PHI_DIV-1 and wraps on each cycle with i_phiM_PCEN_n low. o_phi1=1 iff div_cnt < PHI_DIV/2.
- o_phi1_PCEN_n = ~(phiM_en & div_cnt==PHI_DIV-1). o_phi1_NCEN_n = ~(phiM_en & div_cnt==PHI_DIV/2-1). "NCEN" below means o_phi1_NCEN_n low.
- IC_n: shifted through SYNC_STAGES on phiM enables. The falling edge seen between the last two stages forces div_cnt to 0 on the next phiM enable (phase init). This overrides advance, and no P/NCEN is issued in that cycle.
- o_MRST_n <= second-to-last sync stage, on NCEN.
- Slot counter, on NCEN: forced 0 while o_MRST_n=0; else SLOTS-1 wraps to 0, otherwise increments.
- Strobes, on NCEN: o_STROBE[k] <= en[k] & (o_SLOT==cmp[k]). Held between NCENs.
- Table write on any EMUCLK cycle with i_STB_WE=1:
  - i_STB_SLOT < SLOTS and i_STB_SEL < N_STROBE: entry updated.
  - Otherwise: entry unchanged and o_STB_ERR set; only i_RST clears it.
  - Write coincident with NCEN: decode uses the pre-write entry.
- SH: raw sh1 = slot in [SH1_START, SH1_START+SH_LEN), modulo SLOTS; likewise sh2. Each goes through an SH_DELAY-stage shift register on NCEN, then o_SHx <= tap & o_MRST_n on NCEN.
- o_FRAME <= (o_SLOT==SLOTS-1) & o_MRST_n, on NCEN.
- i_RST assertion mid-frame: everything returns to reset values immediately. After release the table is back at defaults; rewrite is required.

## Timing
- phi1 period = PHI_DIV phiM enables. Exactly one PCEN and one NCEN per period, never in the same cycle.
- IC_n fall to phase init: SYNC_STAGES+1 phiM enables. IC_n rise to o_MRST_n=1: SYNC_STAGES phiM enables, then the next NCEN.
- First NCEN with o_MRST_n=1: o_SLOT still 0. It reaches 1 on the following NCEN.
- Strobe for cmp=c is high for the phi1 cycle in which o_SLOT==c+1 (mod SLOTS).
- o_SHx lags the raw window by SH_DELAY+1 NCENs. High for exactly SH_LEN consecutive phi1 cycles per frame once o_MRST_n=1.
- o_FRAME is high one phi1 cycle per frame, while o_SLOT==0.

## Test plan
- Defaults, PHI_DIV=2, phiM enable every 4th EMUCLK: o_phi1 toggles every enable. PCEN/NCEN alternate. o_SLOT cycles 0..31. o_FRAME high once every 32 NCENs.
- PHI_DIV=6: o_phi1 high 3 enables, low 3 enables. PCEN at div_cnt=5, NCEN at div_cnt=2.
- Program entry 3 as cmp=11, en=1: o_STROBE[3] is high only while o_SLOT==12. Write cmp=40 to entry 3: entry unchanged and o_STB_ERR=1.
- Defaults: o_SH1 is high while o_SLOT is 14..21; o_SH2 while o_SLOT is 30,31,0..5. Both stay 0 until the first full window after o_MRST_n rises.
- IC_n pulse mid-frame: div_cnt resets to 0 after SYNC_STAGES+1 enables. o_MRST_n goes low and o_SLOT holds 0. After release, o_SLOT resumes at 0.
- i_RST asserted at o_SLOT=17 with o_SH1=1: all outputs go to reset values in the same cycle, without waiting for a clock. The table returns to defaults.

Source files
------------

// File: rtl/ikaopm_slotgen.sv
// ikaopm_slotgen: phi1 divider, slot counter, SH windows and runtime-programmable slot strobes
module ikaopm_slotgen #(
  parameter int SLOTS       = 32,
  parameter int SLOT_W      = 5,
  parameter int PHI_DIV     = 2,
  parameter int N_STROBE    = 8,
  parameter int SH1_START   = 8,
  parameter int SH2_START   = 24,
  parameter int SH_LEN      = 8,
  parameter int SH_DELAY    = 5,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W = N_STROBE > 1 ? $clog2(N_STROBE) : 1,
  localparam int DIV_W = $clog2(PHI_DIV)
) (
  input  logic                i_EMUCLK,
  input  logic                i_RST,
  input  logic                i_phiM_PCEN_n,
  input  logic                i_IC_n,
  input  logic                i_STB_WE,
  input  logic [SEL_W-1:0]    i_STB_SEL,
  input  logic [SLOT_W-1:0]   i_STB_SLOT,
  input  logic                i_STB_EN,
  output logic                o_MRST_n,
  output logic                o_phi1,
  output logic                o_phi1_PCEN_n,
  output logic                o_phi1_NCEN_n,
  output logic [SLOT_W-1:0]   o_SLOT,
  output logic [N_STROBE-1:0] o_STROBE,
  output logic                o_SH1,
  output logic                o_SH2,
  output logic                o_FRAME,
  output logic                o_STB_ERR
);
  logic [DIV_W-1:0] div_cnt;
  logic [SYNC_STAGES-1:0] ic_sync;
  logic phim_en, phase_init, pcen, ncen, wr_ok, sh1_raw, sh2_raw;
  logic [SLOT_W-1:0] cmp [N_STROBE];
  logic [N_STROBE-1:0] en;
  logic [SH_DELAY-1:0] sh1_pipe, sh2_pipe;
  logic [SH_DELAY:0] sh1_next, sh2_next;

  function automatic logic in_win(input logic [SLOT_W-1:0] s, input int start);
    return ((int'(s) - (start % SLOTS) + SLOTS) % SLOTS) < SH_LEN;
  endfunction

  assign phim_en = ~i_phiM_PCEN_n;
  // a falling IC_n between the last two stages re-phases the divider and swallows this enable
  assign phase_init = ic_sync[SYNC_STAGES-1] & ~ic_sync[SYNC_STAGES-2];
  assign pcen = phim_en & ~phase_init & (div_cnt == DIV_W'(PHI_DIV - 1));
  assign ncen = phim_en & ~phase_init & (div_cnt == DIV_W'(PHI_DIV / 2 - 1));
  assign o_phi1 = div_cnt < DIV_W'(PHI_DIV / 2);
  assign o_phi1_PCEN_n = ~pcen;
  assign o_phi1_NCEN_n = ~ncen;
  assign wr_ok = (int'(i_STB_SLOT) < SLOTS) & (int'(i_STB_SEL) < N_STROBE);
  assign sh1_raw = in_win(o_SLOT, SH1_START);
  assign sh2_raw = in_win(o_SLOT, SH2_START);
  assign sh1_next = {sh1_pipe, sh1_raw};
  assign sh2_next = {sh2_pipe, sh2_raw};

  always_ff @(posedge i_EMUCLK or posedge i_RST)
    if (i_RST) begin
      div_cnt <= '0;
      ic_sync <= '0;
    end else if (phim_en) begin
      ic_sync <= {ic_sync[SYNC_STAGES-2:0], i_IC_n};
      div_cnt <= (phase_init || div_cnt == DIV_W'(PHI_DIV - 1)) ? '0 : div_cnt + 1'b1;
    end

  always_ff @(posedge i_EMUCLK or posedge i_RST)
    if (i_RST) begin
      o_MRST_n <= 1'b0;
      o_SLOT <= '0;
      o_STROBE <= '0;
      sh1_pipe <= '0;
      sh2_pipe <= '0;
      o_SH1 <= 1'b0;
      o_SH2 <= 1'b0;
      o_FRAME <= 1'b0;
    end else if (ncen) begin
      o_MRST_n <= ic_sync[SYNC_STAGES-2];
      o_SLOT <= (!o_MRST_n || o_SLOT == SLOT_W'(SLOTS - 1)) ? '0 : o_SLOT + 1'b1;
      for (int k = 0; k < N_STROBE; k++) o_STROBE[k] <= en[k] & (o_SLOT == cmp[k]);
      sh1_pipe <= sh1_next[SH_DELAY-1:0];
      sh2_pipe <= sh2_next[SH_DELAY-1:0];
      o_SH1 <= sh1_pipe[SH_DELAY-1] & o_MRST_n;
      o_SH2 <= sh2_pipe[SH_DELAY-1] & o_MRST_n;
      o_FRAME <= (o_SLOT == SLOT_W'(SLOTS - 1)) & o_MRST_n;
    end

  always_ff @(posedge i_EMUCLK or posedge i_RST)
    if (i_RST) begin
      for (int k = 0; k < N_STROBE; k++) cmp[k] <= SLOT_W'(k % SLOTS);
      en <= '0;
      o_STB_ERR <= 1'b0;
    end else if (i_STB_WE) begin
      if (wr_ok) begin
        cmp[i_STB_SEL] <= i_STB_SLOT;
        en[i_STB_SEL] <= i_STB_EN;
      end else o_STB_ERR <= 1'b1;
    end
endmodule

// File: tb/tb_ikaopm_slotgen.sv
// tb_ikaopm_slotgen: scoreboard bench for divider enables, slot counter, strobes, SH windows, IC_n and async reset
module tb_ikaopm_slotgen;
  localparam int SW = 6;
  logic clk = 0, rst = 1, phim_n = 1, ic_n = 1, we = 0, wen = 0;
  logic [2:0] sel = '0;
  logic [SW-1:0] wslot = '0;
  logic mrst_n, phi1, pcen_n, ncen_n, sh1, sh2, frame, err;
  logic [SW-1:0] slot;
  logic [7:0] stb;
  logic mrst6, phi16, pcen6, ncen6, sh16, sh26, frame6, err6;
  logic [4:0] slot6;
  logic [7:0] stb6;
  int tests = 0, fails = 0, ecnt = 0;
  typedef struct packed {logic mrst; logic [SW-1:0] slot; logic [7:0] stb; logic sh1, sh2, frame;} exp_t;
  exp_t q[$];

  ikaopm_slotgen #(.SLOT_W(SW)) dut (
    .i_EMUCLK(clk), .i_RST(rst), .i_phiM_PCEN_n(phim_n), .i_IC_n(ic_n),
    .i_STB_WE(we), .i_STB_SEL(sel), .i_STB_SLOT(wslot), .i_STB_EN(wen),
    .o_MRST_n(mrst_n), .o_phi1(phi1), .o_phi1_PCEN_n(pcen_n), .o_phi1_NCEN_n(ncen_n),
    .o_SLOT(slot), .o_STROBE(stb), .o_SH1(sh1), .o_SH2(sh2), .o_FRAME(frame), .o_STB_ERR(err));

  ikaopm_slotgen #(.PHI_DIV(6)) dut6 (
    .i_EMUCLK(clk), .i_RST(rst), .i_phiM_PCEN_n(phim_n), .i_IC_n(ic_n),
    .i_STB_WE(1'b0), .i_STB_SEL(3'd0), .i_STB_SLOT(5'd0), .i_STB_EN(1'b0),
    .o_MRST_n(mrst6), .o_phi1(phi16), .o_phi1_PCEN_n(pcen6), .o_phi1_NCEN_n(ncen6),
    .o_SLOT(slot6), .o_STROBE(stb6), .o_SH1(sh16), .o_SH2(sh26), .o_FRAME(frame6), .o_STB_ERR(err6));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one phiM enable: combinational enables sampled mid-cycle, then three idle EMUCLKs
  task automatic step(input bit chk_en, output logic nc);
    @(negedge clk);
    phim_n = 0;
    #2;
    nc = ncen_n;
    if (chk_en) begin
      chk("phi1", 32'(phi1), 32'(ecnt % 2 < 1));
      chk("pcen_n", 32'(pcen_n), 32'(ecnt % 2 != 1));
      chk("ncen_n", 32'(ncen_n), 32'(ecnt % 2 != 0));
      chk("phi1_div6", 32'(phi16), 32'(ecnt % 6 < 3));
      chk("pcen_n_div6", 32'(pcen6), 32'(ecnt % 6 != 5));
      chk("ncen_n_div6", 32'(ncen6), 32'(ecnt % 6 != 2));
    end
    ecnt++;
    @(posedge clk);
    #1;
    phim_n = 1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] s, input logic [SW-1:0] c, input logic e);
    @(negedge clk);
    we = 1; sel = s; wslot = c; wen = e;
    @(negedge clk);
    we = 0;
  endtask

  function automatic int sv(int n);
    return n <= 2 ? 0 : (n - 2) % 32;
  endfunction

  function automatic logic win(int s, int st);
    return s >= st && s < st + 8;
  endfunction

  // n-th phi1 cycle after reset release with IC_n high: NCEN enable then PCEN enable
  task automatic run(input int ncyc, input bit prog);
    exp_t e, o;
    logic nc;
    for (int n = 1; n <= ncyc; n++) begin
      e.mrst = n >= 2;
      e.slot = SW'(sv(n));
      e.frame = n > 2 && sv(n) == 0;
      e.stb = (prog && n > 2 && sv(n) == 12) ? 8'h08 : 8'h00;
      e.sh1 = n >= 3 && win(sv(n - 6), 8);
      e.sh2 = n >= 3 && win(sv(n - 6), 24);
      q.push_back(e);
      step(1, nc);
      o = q.pop_front();
      chk("mrst_n", 32'(mrst_n), 32'(o.mrst));
      chk("slot", 32'(slot), 32'(o.slot));
      chk("strobe", 32'(stb), 32'(o.stb));
      chk("sh1", 32'(sh1), 32'(o.sh1));
      chk("sh2", 32'(sh2), 32'(o.sh2));
      chk("frame", 32'(frame), 32'(o.frame));
      step(1, nc);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mrst_n"}, 32'(mrst_n), 32'd0);
    chk({tag, "_phi1"}, 32'(phi1), 32'd1);
    chk({tag, "_pcen_n"}, 32'(pcen_n), 32'd1);
    chk({tag, "_ncen_n"}, 32'(ncen_n), 32'd1);
    chk({tag, "_slot"}, 32'(slot), 32'd0);
    chk({tag, "_strobe"}, 32'(stb), 32'd0);
    chk({tag, "_sh1"}, 32'(sh1), 32'd0);
    chk({tag, "_sh2"}, 32'(sh2), 32'd0);
    chk({tag, "_frame"}, 32'(frame), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic nc;
    int guard;
    repeat (2) @(posedge clk);
    #2;
    chk_reset("rst");
    chk("rst6_mrst_n", 32'(mrst6), 32'd0);
    chk("rst6_phi1", 32'(phi16), 32'd1);
    chk("rst6_slot", 32'(slot6), 32'd0);
    chk("rst6_strobe", 32'(stb6), 32'd0);
    chk("rst6_sh", 32'({sh16, sh26}), 32'd0);
    chk("rst6_frame_err", 32'({frame6, err6}), 32'd0);
    @(negedge clk);
    rst = 0;
    wr(3'd3, SW'(11), 1'b1);
    chk("err_legal", 32'(err), 32'd0);
    wr(3'd3, SW'(40), 1'b1);
    chk("err_illegal", 32'(err), 32'd1);
    wr(3'd5, SW'(7), 1'b0);
    chk("err_sticky", 32'(err), 32'd1);
    run(80, 1'b1);
    chk("idle_pcen_n", 32'(pcen_n), 32'd1);
    chk("idle_ncen_n", 32'(ncen_n), 32'd1);
    ic_n = 0;
    repeat (8) step(1'b0, nc);
    chk("ic_mrst_n", 32'(mrst_n), 32'd0);
    chk("ic_slot", 32'(slot), 32'd0);
    repeat (6) step(1'b0, nc);
    chk("ic_hold_slot", 32'(slot), 32'd0);
    chk("ic_frame", 32'(frame), 32'd0);
    chk("ic_sh1", 32'(sh1), 32'd0);
    ic_n = 1;
    guard = 0;
    while (mrst_n !== 1'b1 && guard < 20) begin
      step(1'b0, nc);
      guard++;
    end
    chk("ic_release", 32'(mrst_n), 32'd1);
    chk("ic_resume0", 32'(slot), 32'd0);
    for (int s = 1; s <= 20; s++) begin
      guard = 0;
      do begin
        step(1'b0, nc);
        guard++;
      end while (nc !== 1'b0 && guard < 4);
      chk("ic_resume", 32'(slot), 32'(s));
    end
    guard = 0;
    while (slot !== SW'(17) && guard < 100) begin
      step(1'b0, nc);
      guard++;
    end
    chk("pre_rst_slot", 32'(slot), 32'd17);
    chk("pre_rst_sh1", 32'(sh1), 32'd1);
    chk("pre_rst_err", 32'(err), 32'd1);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk_reset("async_rst");
    @(negedge clk);
    rst = 0;
    ecnt = 0;
    run(40, 1'b0);
    chk("err_after_rst", 32'(err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
